prog_encoder: RTL and testbench

Instruction encoder and program loader. It is the producer side of the opcode/aluOp fields that the processor's control decoder consumes. It accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit ISA words (R/I/JI/JII formats), and writes them sequentially into instruction memory. It is used by the bench and by boot logic to build programs without hand-assembled hex.

---
 rtl/prog_encoder.sv | 174 +++++++++++++++++
 tb/tb_prog_encoder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_encoder.sv
`default_nettype none
// ============================================================================
// Module      : prog_encoder
// Description : Instruction encoder and program loader. Accepts decoded
//               instruction fields over valid/ready, packs them into 32-bit
//               R/I/JI/JII words and writes them to consecutive
//               instruction-memory addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_encoder #(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_aluop,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [16:0]       in_imm,
    input  logic [26:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              overflow,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       data_q,     data_d;
    logic              last_q,     last_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic              illegal_q,  illegal_d;
    logic              overflow_q, overflow_d;
    // Set once the top address has been written; the address register holds
    // there, and the next legal instruction reports overflow instead of a write.
    logic              full_q,     full_d;

    logic              w_legal;
    logic [31:0]       w_word;

    // Format packing: only the fields owned by each format reach the word.
    always_comb begin
        w_legal = 1'b0;
        w_word  = 32'd0;
        case (in_opcode)
            5'b00000: begin
                w_legal = 1'b1;
                w_word  = {in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            end
            5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110: begin
                w_legal = 1'b1;
                w_word  = {in_opcode, in_rd, in_rs, in_imm};
            end
            5'b00001, 5'b00011, 5'b10110, 5'b10101: begin
                w_legal = 1'b1;
                w_word  = {in_opcode, in_target};
            end
            5'b00100: begin
                w_legal = 1'b1;
                w_word  = {in_opcode, in_rd, 22'd0};
            end
            default: begin
                w_legal = 1'b0;
                w_word  = 32'd0;
            end
        endcase
    end

    // Next-state and session bookkeeping.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        last_d     = last_q;
        count_d    = count_q;
        illegal_d  = illegal_q;
        overflow_d = overflow_q;
        full_d     = full_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d     = c_base_addr;
                    count_d    = '0;
                    illegal_d  = 1'b0;
                    overflow_d = 1'b0;
                    full_d     = 1'b0;
                    state_d    = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    if (!w_legal) begin
                        illegal_d = 1'b1;
                        if (in_last) begin
                            state_d = ST_DONE;
                        end
                    end else if (full_q) begin
                        overflow_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        data_d  = w_word;
                        last_d  = in_last;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                count_d = count_q + (ADDR_W+1)'(1);
                if (&addr_q) begin
                    full_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                state_d = last_q ? ST_DONE : ST_ACCEPT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any session in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= c_base_addr;
            data_q     <= 32'd0;
            last_q     <= 1'b0;
            count_q    <= '0;
            illegal_q  <= 1'b0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            last_q     <= last_d;
            count_q    <= count_d;
            illegal_q  <= illegal_d;
            overflow_q <= overflow_d;
            full_q     <= full_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCEPT);
    assign imem_we   = (state_q == ST_WRITE);
    assign busy      = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);
    assign imem_addr = addr_q;
    assign imem_data = data_q;
    assign illegal   = illegal_q;
    assign overflow  = overflow_q;
    assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_encoder
// Description : Self-checking bench for prog_encoder: directed vector table,
//               multi-cycle corner sequences and random sessions against a
//               field-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_encoder;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  aluop;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [16:0] imm;
        logic [26:0] target;
        logic        last;
    } instr_t;

    typedef struct {
        instr_t      ins;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [4:0]  in_opcode = '0, in_aluop = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0;
    logic [16:0] in_imm = '0;
    logic [26:0] in_target = '0;
    logic        sel = 1'b0;

    logic        ready0, we0, busy0, done0, ill0, ovf0;
    logic [11:0] addr0;
    logic [31:0] data0;
    logic [12:0] cnt0;
    logic        ready1, we1, busy1, done1, ill1, ovf1;
    logic [11:0] addr1;
    logic [31:0] data1;
    logic [12:0] cnt1;

    always #5 clock = ~clock;

    prog_encoder #(.ADDR_W(12), .BASE_ADDR(0)) dut0 (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(ready0),
        .in_last(in_last), .in_opcode(in_opcode), .in_aluop(in_aluop), .in_rd(in_rd),
        .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .imem_we(we0), .imem_addr(addr0), .imem_data(data0), .busy(busy0), .done(done0),
        .illegal(ill0), .overflow(ovf0), .count(cnt0));

    prog_encoder #(.ADDR_W(12), .BASE_ADDR(4094)) dut1 (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(ready1),
        .in_last(in_last), .in_opcode(in_opcode), .in_aluop(in_aluop), .in_rd(in_rd),
        .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .imem_we(we1), .imem_addr(addr1), .imem_data(data1), .busy(busy1), .done(done1),
        .illegal(ill1), .overflow(ovf1), .count(cnt1));

    // View of whichever instance the current test is looking at.
    logic        w_ready, w_we, w_busy, w_done, w_ill, w_ovf;
    logic [11:0] w_addr;
    logic [31:0] w_data;
    logic [12:0] w_cnt;
    assign w_ready = sel ? ready1 : ready0;
    assign w_we    = sel ? we1    : we0;
    assign w_busy  = sel ? busy1  : busy0;
    assign w_done  = sel ? done1  : done0;
    assign w_ill   = sel ? ill1   : ill0;
    assign w_ovf   = sel ? ovf1   : ovf0;
    assign w_addr  = sel ? addr1  : addr0;
    assign w_data  = sel ? data1  : data0;
    assign w_cnt   = sel ? cnt1   : cnt0;

    int n_cmp = 0;
    int n_err = 0;
    int ready_viol = 0;
    logic [11:0] q_addr[$];
    logic [31:0] q_data[$];

    // Write monitor: record every memory write, and flag in_ready during one.
    always @(negedge clock) begin
        if (w_we) begin
            q_addr.push_back(w_addr);
            q_data.push_back(w_data);
            if (w_ready) ready_viol++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] op, input logic [4:0] aluop,
                                  input logic [4:0] rd, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] shamt,
                                  input logic [16:0] imm, input logic [26:0] target,
                                  input logic last);
        instr_t x;
        x.op = op; x.aluop = aluop; x.rd = rd; x.rs = rs; x.rt = rt;
        x.shamt = shamt; x.imm = imm; x.target = target; x.last = last;
        return x;
    endfunction

    // Reference: each format is a list of (field value x bit position) terms.
    function automatic logic [32:0] ref_encode(input instr_t x);
        longint unsigned w;
        int op;
        op = int'(x.op);
        w  = longint'(x.op) * 134217728;
        if (op == 0)
            w += longint'(x.rd) * 4194304 + longint'(x.rs) * 131072 + longint'(x.rt) * 4096
               + longint'(x.shamt) * 128 + longint'(x.aluop) * 4;
        else if (op inside {5, 7, 8, 2, 6})
            w += longint'(x.rd) * 4194304 + longint'(x.rs) * 131072 + longint'(x.imm);
        else if (op inside {1, 3, 22, 21})
            w += longint'(x.target);
        else if (op == 4)
            w += longint'(x.rd) * 4194304;
        else
            return {1'b0, 32'd0};
        return {1'b1, w[31:0]};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send(input instr_t x);
        int n;
        in_opcode = x.op; in_aluop = x.aluop; in_rd = x.rd; in_rs = x.rs; in_rt = x.rt;
        in_shamt = x.shamt; in_imm = x.imm; in_target = x.target; in_last = x.last;
        in_valid = 1'b1;
        n = 0;
        while (!w_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("handshake_ready", 64'(w_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!w_done && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("session_done", 64'(w_done), 64'd1);
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{mk(5'd0,  5'd0,  5'd3,  5'd1,  5'd2,  5'd0, 17'h0,     27'h0,       1'b1), 1'b1, 32'h00C22000};
        vecs[1]  = '{mk(5'd0,  5'd4,  5'd5,  5'd0,  5'd6,  5'd3, 17'h1FFFF, 27'h7FFFFFF, 1'b1), 1'b1, 32'h01406190};
        vecs[2]  = '{mk(5'd5,  5'd31, 5'd1,  5'd0,  5'd31, 5'd31,17'h5,     27'h7FFFFFF, 1'b1), 1'b1, 32'h28400005};
        vecs[3]  = '{mk(5'd8,  5'd0,  5'd2,  5'd29, 5'd0,  5'd0, 17'h10000, 27'h0,       1'b1), 1'b1, 32'h40BB0000};
        vecs[4]  = '{mk(5'd2,  5'd0,  5'd31, 5'd31, 5'd0,  5'd0, 17'h1FFFF, 27'h0,       1'b1), 1'b1, 32'h17FFFFFF};
        vecs[5]  = '{mk(5'd6,  5'd0,  5'd1,  5'd2,  5'd0,  5'd0, 17'h4,     27'h0,       1'b1), 1'b1, 32'h30440004};
        vecs[6]  = '{mk(5'd1,  5'd9,  5'd31, 5'd7,  5'd3,  5'd1, 17'h1F,    27'h10,      1'b1), 1'b1, 32'h08000010};
        vecs[7]  = '{mk(5'd3,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0, 17'h0,     27'h7FFFFFF, 1'b1), 1'b1, 32'h1FFFFFFF};
        vecs[8]  = '{mk(5'd22, 5'd0,  5'd4,  5'd0,  5'd0,  5'd0, 17'h0,     27'h0000ABC, 1'b1), 1'b1, 32'hB0000ABC};
        vecs[9]  = '{mk(5'd21, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0, 17'h3,     27'h1234567, 1'b1), 1'b1, 32'hA9234567};
        vecs[10] = '{mk(5'd4,  5'd3,  5'd31, 5'd7,  5'd9,  5'd2, 17'h1FFFF, 27'h5555555, 1'b1), 1'b1, 32'h27C00000};
        vecs[11] = '{mk(5'd15, 5'd0,  5'd1,  5'd1,  5'd1,  5'd0, 17'h1,     27'h1,       1'b1), 1'b0, 32'h0};
        vecs[12] = '{mk(5'd31, 5'd0,  5'd1,  5'd1,  5'd1,  5'd0, 17'h1,     27'h1,       1'b1), 1'b0, 32'h0};
        vecs[13] = '{mk(5'd9,  5'd0,  5'd1,  5'd1,  5'd1,  5'd0, 17'h1,     27'h1,       1'b1), 1'b0, 32'h0};
    end

    initial begin
        instr_t x;
        logic [32:0] r;
        int nins, nlegal;
        logic exp_ill;
        logic [11:0] e_addr[$];
        logic [31:0] e_data[$];
        logic [4:0] legal_ops[11];
        legal_ops = '{5'd0, 5'd5, 5'd7, 5'd8, 5'd2, 5'd6, 5'd1, 5'd3, 5'd22, 5'd21, 5'd4};

        // Reset state.
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_flags", {59'd0, w_busy, w_done, w_ill, w_ovf, w_we}, 64'd0);
        check("rst_ready", 64'(w_ready), 64'd0);
        check("rst_count", 64'(w_cnt), 64'd0);
        check("rst_data",  64'(w_data), 64'd0);
        check("rst_addr0", 64'(addr0), 64'd0);
        check("rst_addr1", 64'(addr1), 64'd4094);

        // Directed table: one-instruction sessions.
        for (int i = 0; i < 14; i++) begin
            clear_q();
            pulse_start();
            send(vecs[i].ins);
            wait_done();
            check($sformatf("vec%0d_illegal", i), 64'(w_ill), 64'(!vecs[i].legal));
            check($sformatf("vec%0d_count", i), 64'(w_cnt), 64'(vecs[i].legal));
            check($sformatf("vec%0d_nwrites", i), 64'(q_data.size()), 64'(vecs[i].legal));
            if (q_data.size() > 0) begin
                check($sformatf("vec%0d_data", i), 64'(q_data[0]), 64'(vecs[i].word));
                check($sformatf("vec%0d_addr", i), 64'(q_addr[0]), 64'd0);
            end
        end

        // addi / sw / j with start pulses while busy.
        clear_q();
        ready_viol = 0;
        pulse_start();
        send(mk(5'd5, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0));
        pulse_start();
        pulse_start();
        send(mk(5'd7, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 17'd3, 27'd0, 1'b0));
        send(mk(5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h10, 1'b1));
        wait_done();
        check("seq3_count", 64'(w_cnt), 64'd3);
        check("seq3_nwrites", 64'(q_data.size()), 64'd3);
        check("seq3_ready_in_write", 64'(ready_viol), 64'd0);
        if (q_data.size() == 3) begin
            check("seq3_w0", {20'd0, q_addr[0], q_data[0]}, {20'd0, 12'd0, 32'h28400005});
            check("seq3_w1", {20'd0, q_addr[1], q_data[1]}, {20'd0, 12'd1, 32'h38400003});
            check("seq3_w2", {20'd0, q_addr[2], q_data[2]}, {20'd0, 12'd2, 32'h08000010});
        end

        // Illegal opcode mid-session, then jr.
        clear_q();
        pulse_start();
        send(mk(5'd15, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 17'd1, 27'd1, 1'b0));
        send(mk(5'd4, 5'd0, 5'd31, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b1));
        wait_done();
        check("ill_flag", 64'(w_ill), 64'd1);
        check("ill_count", 64'(w_cnt), 64'd1);
        check("ill_nwrites", 64'(q_data.size()), 64'd1);
        if (q_data.size() == 1)
            check("ill_w0", {20'd0, q_addr[0], q_data[0]}, {20'd0, 12'd0, 32'h27C00000});

        // in_valid while DONE is ignored.
        clear_q();
        in_opcode = 5'd5; in_last = 1'b0; in_valid = 1'b1;
        repeat (4) @(negedge clock);
        in_valid = 1'b0;
        check("done_valid_nwrites", 64'(q_data.size()), 64'd0);
        check("done_valid_count", 64'(w_cnt), 64'd1);
        check("done_valid_done", 64'(w_done), 64'd1);

        // Top-of-memory overflow on the BASE_ADDR=4094 instance.
        sel = 1'b1;
        clear_q();
        pulse_start();
        send(mk(5'd5, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0, 1'b0));
        send(mk(5'd5, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 17'd2, 27'd0, 1'b0));
        send(mk(5'd5, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 17'd3, 27'd0, 1'b1));
        wait_done();
        check("ovf_flag", 64'(w_ovf), 64'd1);
        check("ovf_count", 64'(w_cnt), 64'd2);
        check("ovf_nwrites", 64'(q_data.size()), 64'd2);
        if (q_data.size() == 2) begin
            check("ovf_a0", 64'(q_addr[0]), 64'd4094);
            check("ovf_a1", 64'(q_addr[1]), 64'd4095);
        end
        repeat (3) @(negedge clock);
        sel = 1'b0;

        // Asynchronous reset while in WRITE.
        pulse_start();
        in_opcode = 5'd5; in_rd = 5'd7; in_rs = 5'd0; in_imm = 17'd9; in_last = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !w_ready; n++) @(negedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        check("rstw_in_write", 64'(w_we), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rstw_we_async", 64'(w_we), 64'd0);
        check("rstw_busy_async", 64'(w_busy), 64'd0);
        clear_q();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rstw_no_write", 64'(q_data.size()), 64'd0);
        check("rstw_idle", {62'd0, w_busy, w_ready}, 64'd0);
        pulse_start();
        send(mk(5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h55, 1'b1));
        wait_done();
        check("rstw_restart_n", 64'(q_data.size()), 64'd1);
        if (q_data.size() == 1)
            check("rstw_restart", {20'd0, q_addr[0], q_data[0]}, {20'd0, 12'd0, 32'h08000055});

        // Random sessions against the reference model.
        for (int s = 0; s < 40; s++) begin
            clear_q();
            e_addr.delete();
            e_data.delete();
            exp_ill = 1'b0;
            nlegal = 0;
            nins = $urandom_range(1, 6);
            pulse_start();
            for (int k = 0; k < nins; k++) begin
                x.op     = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 10)] : 5'($urandom);
                x.aluop  = 5'($urandom);
                x.rd     = 5'($urandom);
                x.rs     = 5'($urandom);
                x.rt     = 5'($urandom);
                x.shamt  = 5'($urandom);
                x.imm    = 17'($urandom);
                x.target = 27'($urandom);
                x.last   = (k == nins - 1);
                r = ref_encode(x);
                if (r[32]) begin
                    e_addr.push_back(12'(nlegal));
                    e_data.push_back(r[31:0]);
                    nlegal++;
                end else begin
                    exp_ill = 1'b1;
                end
                repeat ($urandom_range(0, 2)) @(negedge clock);
                send(x);
            end
            wait_done();
            check($sformatf("rnd%0d_count", s), 64'(w_cnt), 64'(nlegal));
            check($sformatf("rnd%0d_illegal", s), 64'(w_ill), 64'(exp_ill));
            check($sformatf("rnd%0d_overflow", s), 64'(w_ovf), 64'd0);
            check($sformatf("rnd%0d_nwrites", s), 64'(q_data.size()), 64'(e_data.size()));
            for (int k = 0; k < q_data.size() && k < e_data.size(); k++)
                check($sformatf("rnd%0d_w%0d", s, k), {20'd0, q_addr[k], q_data[k]},
                      {20'd0, e_addr[k], e_data[k]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
